// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide engine.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_seq_if.sv
// Request/result bundle between the control FSM (master) and the multdiv engine (slave).
interface multdiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, signed_op, a, b, abort,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, signed_op, a, b, abort,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/multdiv_step.sv
// One radix-2 iteration on magnitudes. Accumulator layout: mult {partial(W+1), multiplier(W)},
// div {remainder(W+1), dividend/quotient(W)}.
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_op,
  input  logic [WIDTH:0]   i_m,
  input  logic [2*WIDTH:0] i_acc,
  output logic [2*WIDTH:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_upper;
  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_sum   = i_acc[2*WIDTH:WIDTH] + i_m;
  assign w_upper = i_acc[0] ? w_sum : i_acc[2*WIDTH:WIDTH];
  assign w_trial = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff  = w_trial - i_m;
  assign w_ge    = (w_trial >= i_m);

  always_comb begin
    o_acc = i_acc;
    if (i_op == OP_MULT) begin
      o_acc = {1'b0, w_upper, i_acc[WIDTH-1:1]};
    end else if (w_ge) begin
      o_acc = {w_diff, i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = {w_trial, i_acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/multdiv_seq.sv
// Shared iterative multiply/divide engine with HI/LO result registers.
// IDLE: wait start | CALC: retire bits | FIX: sign fix, write hi/lo | DONE: done pulse
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  multdiv_seq_if.slave bus
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH:0]   r_m;
  logic [2*WIDTH:0] r_acc;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH:0]   w_mag_a;
  logic [WIDTH:0]   w_mag_b;
  logic             w_zero_div;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [2*WIDTH:0] w_chain [0:BITS_PER_CYCLE];

  // Magnitudes carry one extra bit so |MIN| is representable.
  assign w_sa       = bus.signed_op & bus.a[WIDTH-1];
  assign w_sb       = bus.signed_op & bus.b[WIDTH-1];
  assign w_mag_a    = w_sa ? -{1'b1, bus.a} : {1'b0, bus.a};
  assign w_mag_b    = w_sb ? -{1'b1, bus.b} : {1'b0, bus.b};
  assign w_zero_div = (bus.op == OP_DIV) && (bus.b == '0);

  assign w_prod = r_neg_q ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  assign w_chain[0] = r_acc;
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    multdiv_step #(.WIDTH(WIDTH)) u_step (
      .i_op  (r_op),
      .i_m   (r_m),
      .i_acc (w_chain[g]),
      .o_acc (w_chain[g+1])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= OP_MULT;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_m        <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_div_zero <= 1'b0;
          if (bus.start) begin
            r_op    <= bus.op;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_m     <= (bus.op == OP_DIV) ? w_mag_b : w_mag_a;
            r_acc   <= {{(WIDTH+1){1'b0}},
                        (bus.op == OP_DIV) ? w_mag_a[WIDTH-1:0] : w_mag_b[WIDTH-1:0]};
            if (w_zero_div) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_state <= CALC;
              r_busy  <= 1'b1;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        CALC: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_chain[BITS_PER_CYCLE];
            if (r_cnt == '0) begin
              r_state <= FIX;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        FIX: begin
          r_busy <= 1'b0;
          if (bus.abort) begin
            r_state <= IDLE;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
            if (r_op == OP_MULT) begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed checks of multdiv_seq at 32-bit/radix-2 and 8-bit/4-bits-per-cycle.
module tb_multdiv_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multdiv_seq_if #(.WIDTH(32)) bw ();
  multdiv_seq_if #(.WIDTH(8))  bn ();

  multdiv_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_w (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bw.slave)
  );

  multdiv_seq #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_n (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bn.slave)
  );

  int checks   = 0;
  int failures = 0;
  int lat;
  int pulses;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_w(input logic op, input logic sg, input logic [31:0] a, input logic [31:0] b);
    bw.op = op; bw.signed_op = sg; bw.a = a; bw.b = b; bw.start = 1'b1;
    tick();
    bw.start = 1'b0;
    lat = 1;
  endtask

  task automatic wait_w();
    while (!bw.done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic go_n(input logic op, input logic sg, input logic [7:0] a, input logic [7:0] b);
    bn.op = op; bn.signed_op = sg; bn.a = a; bn.b = b; bn.start = 1'b1;
    tick();
    bn.start = 1'b0;
    lat = 1;
  endtask

  task automatic wait_n();
    while (!bn.done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    reset = 1'b1;
    bw.start = 0; bw.op = 0; bw.signed_op = 0; bw.a = 0; bw.b = 0; bw.abort = 0;
    bn.start = 0; bn.op = 0; bn.signed_op = 0; bn.a = 0; bn.b = 0; bn.abort = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bw.busy), 64'd0);
    check("rst_done", 64'(bw.done), 64'd0);
    check("rst_dz",   64'(bw.div_zero), 64'd0);
    check("rst_hi",   64'(bw.hi), 64'd0);
    check("rst_lo",   64'(bw.lo), 64'd0);
    reset = 1'b0;
    tick();

    // unsigned max * max
    go_w(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("umul_busy", 64'(bw.busy), 64'd1);
    wait_w();
    check("umul_lat", 64'(lat), 64'd34);
    check("umul_hi",  64'(bw.hi), 64'hFFFF_FFFE);
    check("umul_lo",  64'(bw.lo), 64'h0000_0001);
    check("umul_dz",  64'(bw.div_zero), 64'd0);
    tick();
    check("umul_done_1cyc", 64'(bw.done), 64'd0);

    go_w(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
    wait_w();
    check("smul_hi", 64'(bw.hi), 64'hFFFF_FFFF);
    check("smul_lo", 64'(bw.lo), 64'hFFFF_FFEB);
    tick();

    go_w(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_w();
    check("sdiv_lat", 64'(lat), 64'd34);
    check("sdiv_lo",  64'(bw.lo), 64'hFFFF_FFFD);
    check("sdiv_hi",  64'(bw.hi), 64'hFFFF_FFFF);
    tick();

    // zero divisor keeps the previous hi/lo
    go_w(1'b1, 1'b1, 32'd123, 32'd0);
    wait_w();
    check("dz_lat",  64'(lat), 64'd1);
    check("dz_flag", 64'(bw.div_zero), 64'd1);
    check("dz_hi",   64'(bw.hi), 64'hFFFF_FFFF);
    check("dz_lo",   64'(bw.lo), 64'hFFFF_FFFD);
    tick();
    check("dz_done_1cyc", 64'(bw.done), 64'd0);
    check("dz_flag_clr",  64'(bw.div_zero), 64'd0);

    go_w(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_w();
    check("sdiv2_lo", 64'(bw.lo), 64'hFFFF_FFFD);
    check("sdiv2_hi", 64'(bw.hi), 64'h0000_0001);
    tick();

    go_w(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_w();
    check("minneg1_lo", 64'(bw.lo), 64'h8000_0000);
    check("minneg1_hi", 64'(bw.hi), 64'h0000_0000);
    check("minneg1_dz", 64'(bw.div_zero), 64'd0);
    tick();

    go_w(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    wait_w();
    check("udiv_lo", 64'(bw.lo), 64'h0FFF_FFFF);
    check("udiv_hi", 64'(bw.hi), 64'h0000_000F);
    tick();

    // start during CALC must not disturb the operation in flight
    go_w(1'b0, 1'b0, 32'd6, 32'd7);
    repeat (4) begin tick(); lat++; end
    bw.op = 1'b1; bw.a = 32'd1; bw.b = 32'd0; bw.start = 1'b1;
    tick(); lat++;
    bw.start = 1'b0;
    check("ign_busy", 64'(bw.busy), 64'd1);
    check("ign_done", 64'(bw.done), 64'd0);
    wait_w();
    check("ign_lat", 64'(lat), 64'd34);
    check("ign_hi",  64'(bw.hi), 64'd0);
    check("ign_lo",  64'(bw.lo), 64'd42);
    tick();

    // back-to-back: next start presented in the DONE cycle
    go_w(1'b0, 1'b0, 32'd100, 32'd3);
    wait_w();
    check("b2b1_lo", 64'(bw.lo), 64'd300);
    go_w(1'b1, 1'b0, 32'd100, 32'd3);
    wait_w();
    check("b2b2_lat", 64'(lat), 64'd34);
    check("b2b2_lo",  64'(bw.lo), 64'd33);
    check("b2b2_hi",  64'(bw.hi), 64'd1);
    tick();

    // abort in CALC cycle 10
    go_w(1'b0, 1'b0, 32'd5, 32'd5);
    repeat (9) tick();
    check("abt_busy_pre", 64'(bw.busy), 64'd1);
    bw.abort = 1'b1;
    tick();
    bw.abort = 1'b0;
    check("abt_busy", 64'(bw.busy), 64'd0);
    pulses = 0;
    repeat (40) begin
      tick();
      if (bw.done) pulses++;
    end
    check("abt_no_done", 64'(pulses), 64'd0);
    check("abt_hi", 64'(bw.hi), 64'd1);
    check("abt_lo", 64'(bw.lo), 64'd33);

    // synchronous reset mid-CALC
    go_w(1'b0, 1'b0, 32'd9, 32'd9);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("mrst_busy", 64'(bw.busy), 64'd0);
    check("mrst_done", 64'(bw.done), 64'd0);
    check("mrst_dz",   64'(bw.div_zero), 64'd0);
    check("mrst_hi",   64'(bw.hi), 64'd0);
    check("mrst_lo",   64'(bw.lo), 64'd0);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      tick();
      if (bw.done) pulses++;
    end
    check("mrst_no_done", 64'(pulses), 64'd0);

    // 8-bit, 4 bits per cycle
    go_n(1'b0, 1'b0, 8'd200, 8'd7);
    wait_n();
    check("n_mul_lat", 64'(lat), 64'd4);
    check("n_mul_hi",  64'(bn.hi), 64'h05);
    check("n_mul_lo",  64'(bn.lo), 64'h78);
    tick();

    go_n(1'b1, 1'b0, 8'd200, 8'd7);
    wait_n();
    check("n_div_lat", 64'(lat), 64'd4);
    check("n_div_lo",  64'(bn.lo), 64'd28);
    check("n_div_hi",  64'(bn.hi), 64'd4);
    tick();

    go_n(1'b0, 1'b1, 8'h80, 8'hFF);
    wait_n();
    check("n_smul_hi", 64'(bn.hi), 64'h00);
    check("n_smul_lo", 64'(bn.lo), 64'h80);
    tick();

    go_n(1'b1, 1'b1, 8'h80, 8'd3);
    wait_n();
    check("n_sdiv_lo", 64'(bn.lo), 64'hD6);
    check("n_sdiv_hi", 64'(bn.hi), 64'hFE);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
